// File: rtl/bus_pkg.sv
// Shared constants and helpers for the bs_gnrtr_n_rbtr device endpoint.
//   ADDR_W    : width of the destination ID field at the top of a packet
//   BROADCAST : destination ID accepted by every device
//   pkt_dest  : extracts the destination ID from a packet of width pkt_w
package bus_pkg;

  localparam int unsigned ADDR_W    = 8;
  // Widest packet pkt_dest can take apart.
  localparam int unsigned PKT_MAX_W = 64;

  localparam logic [ADDR_W-1:0] BROADCAST = 8'hFF;

  // Top ADDR_W bits of a pkt_w-bit packet (packet zero-extended into pkt).
  function automatic logic [ADDR_W-1:0] pkt_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int unsigned         pkt_w);
    return ADDR_W'(pkt >> (pkt_w - ADDR_W));
  endfunction

endpackage

// File: rtl/bus_fifo.sv
// Synchronous show-ahead FIFO used for both directions of the device port.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   wr, din    : write strobe and data; ignored while full
//   rd         : advance head; ignored while empty
//   dout       : head entry, reads 0 while empty
//   full/empty : decoded from the registered pointers only
module bus_fifo
  import bus_pkg::*;
#(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [width-1:0] r_mem [depth];

  logic w_wr_en;
  logic w_rd_en;

  // Full: same index, opposite wrap bit. Empty: pointers identical.
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty   = (r_wr_ptr == r_rd_ptr);

  // Gating on registered state means a full FIFO rejects a write even when
  // a read is accepted in the same cycle, and an empty one ignores reads.
  assign w_wr_en = wr && !full;
  assign w_rd_en = rd && !empty;

  // Show-ahead head; forced to 0 when empty so stale entries never leak out.
  assign dout    = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bus_device_port.sv
// Device-side endpoint of the bs_gnrtr_n_rbtr bus.
//   TX : host writes (tx_wr/tx_data) are queued and shown to the bus as
//        pndng/D_pop; each bus pop releases one entry. tx_full, tx_ovf_cnt.
//   RX : bus deliveries (push/D_push) addressed to dev_id or broadcast are
//        queued for the host (rx_rd/rx_data/rx_empty); addressed packets
//        arriving while full are counted in rx_drop_cnt.
// Counters saturate at 255. pckg_sz must be 9..64, depth a power of two >= 2.
module bus_device_port
  import bus_pkg::*;
#(
  parameter int unsigned       pckg_sz   = 16,
  parameter int unsigned       depth     = 8,
  parameter logic [ADDR_W-1:0] dev_id    = 8'd0,
  parameter logic [ADDR_W-1:0] broadcast = BROADCAST
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_empty,
  output logic [7:0]         tx_ovf_cnt,
  output logic [7:0]         rx_drop_cnt
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0]  r_tx_ovf_cnt;
  logic [CNT_W-1:0]  r_rx_drop_cnt;

  logic              w_tx_empty;
  logic              w_rx_full;
  logic [ADDR_W-1:0] w_dest;
  logic              w_match;
  logic              w_rx_wr;

  // Address filter on incoming bus packets
  assign w_dest  = pkt_dest(PKT_MAX_W'(D_push), pckg_sz);
  assign w_match = (w_dest == dev_id) || (w_dest == broadcast);
  assign w_rx_wr = push && w_match;

  // TX queue: host -> bus
  bus_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_wr),
    .rd    (pop),
    .din   (tx_data),
    .dout  (D_pop),
    .full  (tx_full),
    .empty (w_tx_empty)
  );

  // RX queue: bus -> host
  bus_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (w_rx_wr),
    .rd    (rx_rd),
    .din   (D_push),
    .dout  (rx_data),
    .full  (w_rx_full),
    .empty (rx_empty)
  );

  assign pndng = !w_tx_empty;

  // Saturating loss counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_ovf_cnt  <= '0;
      r_rx_drop_cnt <= '0;
    end else begin
      if (tx_wr && tx_full && (r_tx_ovf_cnt != '1))
        r_tx_ovf_cnt <= r_tx_ovf_cnt + CNT_W'(1);
      if (w_rx_wr && w_rx_full && (r_rx_drop_cnt != '1))
        r_rx_drop_cnt <= r_rx_drop_cnt + CNT_W'(1);
    end
  end

  assign tx_ovf_cnt  = r_tx_ovf_cnt;
  assign rx_drop_cnt = r_rx_drop_cnt;

endmodule

// File: tb/tb_bus_device_port.sv
// Directed bench for bus_device_port (pckg_sz=16, depth=8, dev_id=3).
module tb_bus_device_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_wr;
  logic [15:0] tx_data;
  logic        tx_full;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        rx_rd;
  logic [15:0] rx_data;
  logic        rx_empty;
  logic [7:0]  tx_ovf_cnt;
  logic [7:0]  rx_drop_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bus_device_port #(
    .pckg_sz   (16),
    .depth     (8),
    .dev_id    (8'd3),
    .broadcast (8'hFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_wr       (tx_wr),
    .tx_data     (tx_data),
    .tx_full     (tx_full),
    .pndng       (pndng),
    .D_pop       (D_pop),
    .pop         (pop),
    .push        (push),
    .D_push      (D_push),
    .rx_rd       (rx_rd),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .tx_ovf_cnt  (tx_ovf_cnt),
    .rx_drop_cnt (rx_drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tx_data = '0; D_push = '0;
    idle();
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_pndng",    16'(pndng),       16'd0);
    chk("rst_tx_full",  16'(tx_full),     16'd0);
    chk("rst_rx_empty", 16'(rx_empty),    16'd1);
    chk("rst_D_pop",    D_pop,            16'h0000);
    chk("rst_rx_data",  rx_data,          16'h0000);
    chk("rst_ovf",      16'(tx_ovf_cnt),  16'd0);
    chk("rst_drop",     16'(rx_drop_cnt), 16'd0);

    // Three writes, then pop them out in order; no bypass before the edge
    tx_wr = 1'b1; tx_data = 16'h0211; #1;
    chk("nobypass_pndng", 16'(pndng), 16'd0);
    chk("nobypass_D_pop", D_pop,      16'h0000);
    tick();
    chk("wr1_pndng", 16'(pndng), 16'd1);
    chk("wr1_D_pop", D_pop,      16'h0211);
    tx_data = 16'h0322; tick();
    tx_data = 16'h0433; tick();
    tx_wr = 1'b0;
    chk("tx3_D_pop", D_pop, 16'h0211);
    pop = 1'b1; tick();
    chk("pop1_D_pop", D_pop, 16'h0322);
    tick();
    chk("pop2_D_pop", D_pop, 16'h0433);
    tick();
    pop = 1'b0;
    chk("pop3_pndng", 16'(pndng), 16'd0);
    chk("pop3_D_pop", D_pop,      16'h0000);

    // Pop on empty TX and read on empty RX change nothing
    pop = 1'b1; rx_rd = 1'b1; tick(); idle();
    chk("epop_pndng",    16'(pndng),    16'd0);
    chk("epop_D_pop",    D_pop,         16'h0000);
    chk("epop_tx_full",  16'(tx_full),  16'd0);
    chk("erd_rx_empty",  16'(rx_empty), 16'd1);
    chk("erd_rx_data",   rx_data,       16'h0000);

    // Write+pop on empty: pop ignored; write+pop on 1 entry: occupancy holds
    tx_wr = 1'b1; pop = 1'b1; tx_data = 16'h0555; tick();
    chk("wpe_pndng", 16'(pndng), 16'd1);
    chk("wpe_D_pop", D_pop,      16'h0555);
    tx_data = 16'h0666; tick();
    chk("wp1_pndng", 16'(pndng), 16'd1);
    chk("wp1_D_pop", D_pop,      16'h0666);
    tx_wr = 1'b0; tick(); idle();
    chk("wp_drain_pndng", 16'(pndng), 16'd0);

    // Fill TX to 8, 9th rejected, 10th with pop still rejected
    tx_wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_data = 16'h0100 + 16'(i);
      tick();
    end
    chk("full8_tx_full", 16'(tx_full),    16'd1);
    chk("full8_ovf",     16'(tx_ovf_cnt), 16'd0);
    tx_data = 16'h0108; tick();
    chk("wr9_ovf",     16'(tx_ovf_cnt), 16'd1);
    chk("wr9_tx_full", 16'(tx_full),    16'd1);
    tx_data = 16'h0109; pop = 1'b1; tick(); idle();
    chk("wr10_ovf",     16'(tx_ovf_cnt), 16'd2);
    chk("wr10_tx_full", 16'(tx_full),    16'd0);
    chk("wr10_D_pop",   D_pop,           16'h0101);
    pop = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    idle();
    chk("tx_drain_pndng", 16'(pndng), 16'd0);

    // RX address filter with dev_id=3
    push = 1'b1;
    D_push = 16'h03AA; tick();
    D_push = 16'h05BB; tick();
    D_push = 16'hFFCC; tick();
    idle();
    chk("rxf_empty", 16'(rx_empty),    16'd0);
    chk("rxf_head0", rx_data,          16'h03AA);
    rx_rd = 1'b1; tick();
    chk("rxf_head1", rx_data,          16'hFFCC);
    tick(); idle();
    chk("rxf_drained", 16'(rx_empty),  16'd1);
    chk("rxf_drop",    16'(rx_drop_cnt), 16'd0);

    // Fill RX, overflow push, then read+push while full
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      D_push = 16'h0310 + 16'(i);
      tick();
    end
    D_push = 16'h0301; tick();
    chk("rxfull_drop1", 16'(rx_drop_cnt), 16'd1);
    D_push = 16'h0302; rx_rd = 1'b1; tick(); idle();
    chk("rxfull_drop2", 16'(rx_drop_cnt), 16'd2);
    for (int i = 1; i < 8; i++) begin
      chk("rx_seq", rx_data, 16'h0310 + 16'(i));
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    end
    chk("rx7_empty", 16'(rx_empty), 16'd1);

    // Overflow counter saturates at 255
    tx_wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_data = 16'h0200 + 16'(i);
      tick();
    end
    for (int i = 0; i < 260; i++) tick();
    idle();
    chk("sat_ovf",     16'(tx_ovf_cnt), 16'd255);
    chk("sat_tx_full", 16'(tx_full),    16'd1);
    chk("sat_D_pop",   D_pop,           16'h0200);
    pop = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    idle();
    chk("half_D_pop", D_pop,         16'h0204);
    chk("half_full",  16'(tx_full),  16'd0);

    // RX holds two entries, then reset mid-operation with requests pending
    push = 1'b1;
    D_push = 16'h0341; tick();
    D_push = 16'hFF42; tick();
    idle();
    chk("pre_rst_rx", rx_data, 16'h0341);
    reset = 1'b1; tx_wr = 1'b1; tx_data = 16'h0777; push = 1'b1; D_push = 16'h0399;
    tick();
    reset = 1'b0; idle();
    chk("mrst_pndng",    16'(pndng),       16'd0);
    chk("mrst_rx_empty", 16'(rx_empty),    16'd1);
    chk("mrst_ovf",      16'(tx_ovf_cnt),  16'd0);
    chk("mrst_drop",     16'(rx_drop_cnt), 16'd0);
    chk("mrst_D_pop",    D_pop,            16'h0000);
    chk("mrst_tx_full",  16'(tx_full),     16'd0);
    tx_wr = 1'b1; tx_data = 16'h0099; #1;
    chk("post_nobypass", 16'(pndng), 16'd0);
    tick(); idle();
    chk("post_D_pop", D_pop,      16'h0099);
    chk("post_pndng", 16'(pndng), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_device_port.md
# bus_device_port

Device-side endpoint of the `bs_gnrtr_n_rbtr` bus. It replaces the behavioural FIFO model the bench uses today with synthesizable RTL.
- TX path: buffers packets written by the local host, presents them to the bus as `pndng`/`D_pop`, and releases one per bus `pop`.
- RX path: captures bus deliveries (`push`/`D_push`), keeps only packets addressed to this device or to broadcast, and buffers them for the host.

One instance per bus device, indexed by `dev_id`.

## Interface
Parameters:
- `pckg_sz`, 16: packet width in bits. Bits [pckg_sz-1 -: 8] hold the destination ID; the remaining bits are payload. Must be ≥ 9.
- `depth`, 8: entries per FIFO. Must be a power of two, ≥ 2.
- `dev_id`, 0: this device's 8-bit ID.
- `broadcast`, 8'hFF: destination ID that every device accepts.

Ports:
- `clk` in 1: sole clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `tx_wr` in 1: host write strobe.
- `tx_data` in pckg_sz: packet to transmit.
- `tx_full` out 1: TX FIFO holds `depth` entries.
- `pndng` out 1: TX FIFO is non-empty. Bus side.
- `D_pop` out pckg_sz: TX head entry, show-ahead. Bus side.
- `pop` in 1: bus consumed the head entry.
- `push` in 1: bus delivers a packet.
- `D_push` in pckg_sz: delivered packet.
- `rx_rd` in 1: host read strobe.
- `rx_data` out pckg_sz: RX head entry, show-ahead.
- `rx_empty` out 1: RX FIFO is empty.
- `tx_ovf_cnt` out 8: count of rejected host writes. Saturates at 255.
- `rx_drop_cnt` out 8: count of addressed packets lost because the RX FIFO was full. Saturates at 255.

## Operation
- **Reset values:** both FIFOs empty, so `pndng`=0, `tx_full`=0, `rx_empty`=1. `D_pop`=0, `rx_data`=0, both counters 0.
- **TX write:**
  - `tx_wr` with `tx_full`=0 stores `tx_data` at the tail.
  - `tx_wr` with `tx_full`=1 drops the data and increments `tx_ovf_cnt`.
  - A write while full is rejected even if `pop` is asserted in the same cycle. Fullness is judged on the registered state.
- **TX pop:**
  - `pop` with `pndng`=1 advances the head.
  - `pop` with `pndng`=0 is ignored: no pointer change, no error.
  - `tx_wr` and `pop` together on a non-full, non-empty FIFO: occupancy is unchanged and both complete.
  - Write to an empty FIFO together with `pop`: the pop is ignored and the write completes.
- **RX filter:** `push` is accepted when `D_push[pckg_sz-1 -: 8]` equals `dev_id` or `broadcast`. Other destinations are discarded silently and are not counted.
- **RX store:**
  - An accepted packet with the RX FIFO not full is stored whole, address byte included.
  - An accepted packet with the RX FIFO full is discarded and increments `rx_drop_cnt`.
  - Full/empty and simultaneous read/write rules mirror the TX path, with `rx_rd` in place of `pop`.
- **Pointers and counters:**
  - Pointers are log2(depth) bits plus one wrap bit.
  - Full: indices equal, wrap bits differ. Empty: pointers fully equal.
  - Counters hold at 255.

## Timing
- Write to pop visibility: data written in cycle N appears on `D_pop` with `pndng`=1 after edge N.
- There is no bypass: an empty FIFO never presents same-cycle write data.
- `pop` sampled at edge N updates `D_pop` to the next entry immediately after edge N. `pndng` falls after edge N if that was the last entry.
- RX: a matching `push` at edge N gives `rx_empty`=0 and valid `rx_data` after edge N.
- `tx_full`, `pndng` and `rx_empty` are decoded from registered pointers. They never depend combinationally on the same-cycle `tx_wr`, `pop`, `push` or `rx_rd`.
- Reset asserted mid-operation empties both FIFOs and zeroes both counters at that edge. Requests in the reset cycle are ignored.

## Structure
- Package `bus_pkg` holds:
  - `ADDR_W = 8` and the default `BROADCAST` constant.
  - Function `pkt_dest(pkt)` returning the top 8 bits.
- Sub-module `bus_fifo #(width, depth)`: synchronous show-ahead FIFO with `wr`, `rd`, `din`, `dout`, `full`, `empty`.
  - It is instantiated twice, once for TX and once for RX.
  - The address filter and the saturating counters live in `bus_device_port`.

## Test plan
- Reset, then write 3 packets 16'h0211, 16'h0322, 16'h0433 → `pndng`=1, `D_pop`=16'h0211. Three `pop` cycles yield 16'h0322, then 16'h0433, then `pndng`=0.
- `depth`=8: 9 consecutive writes → `tx_full`=1 after the 8th, `tx_ovf_cnt`=1. A 10th write together with `pop` → still rejected, `tx_ovf_cnt`=2.
- `dev_id`=3: pushes 16'h03AA, 16'h05BB, 16'hFFCC → RX holds 16'h03AA then 16'hFFCC, `rx_drop_cnt`=0.
- Fill RX with 8 matching packets, then push 16'h0301 → `rx_drop_cnt`=1. `rx_rd` together with a matching push when full → push dropped, `rx_drop_cnt`=2, occupancy becomes 7.
- `pop` on empty TX and `rx_rd` on empty RX → no state change, outputs stay at reset values.
- TX half full and RX holding 2 entries, assert `reset` one cycle → `pndng`=0, `rx_empty`=1, both counters 0 on the next cycle. A following write of 16'h0099 appears on `D_pop` after one edge.
